irq_sequencer: RTL and testbench

- Parametrised, multi-channel successor to the core's single-line interrupt path.
- Latches N_IRQ interrupt requests in edge or level mode, with per-channel masking and fixed priority.
- On acceptance it stalls and flushes fetch, drains the pipeline, and pushes the resume PC and flags to the stack through a valid/ready port. It then redirects the PC to a per-channel vector and holds off further interrupts until RTI retires.
- Sits beside the hazard controller; its stall/flush outputs are OR-ed into the fetch stage.

---
 rtl/irq_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_irq_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_sequencer.sv
// Multi-channel interrupt sequencer: latches requests, drains fetch, pushes the
// resume PC and flags to the stack, then redirects the PC to a per-channel vector.
module irq_sequencer #(
    parameter int                  N_IRQ         = 4,
    parameter int                  PC_WIDTH      = 32,
    parameter bit                  EDGE_MODE     = 1'b1,
    parameter int                  DRAIN_CYCLES  = 3,
    parameter logic [PC_WIDTH-1:0] VECTOR_BASE   = '0,
    parameter int                  VECTOR_STRIDE = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [N_IRQ-1:0]                           irq_in,
    input  logic                                       mask_we,
    input  logic [N_IRQ-1:0]                           mask_wdata,
    input  logic                                       branch_pending,
    input  logic [PC_WIDTH-1:0]                        pc_resume,
    input  logic [2:0]                                 flags_in,
    output logic                                       push_valid,
    output logic [15:0]                                push_data,
    input  logic                                       push_ready,
    output logic                                       stall_fetch,
    output logic                                       flush_fetch,
    output logic                                       pc_write,
    output logic [PC_WIDTH-1:0]                        pc_value,
    input  logic                                       rti,
    output logic                                       in_service,
    output logic [((N_IRQ > 1) ? $clog2(N_IRQ) : 1)-1:0] active_id,
    output logic [N_IRQ-1:0]                           pending
);

    localparam int ID_W    = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam int N_WORDS = PC_WIDTH / 16 + 1;
    localparam int WORD_W  = $clog2(N_WORDS + 1);
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [WORD_W-1:0]   WORD_LAST  = WORD_W'(N_WORDS - 1);
    localparam logic [PC_WIDTH-1:0] STRIDE_PC  = PC_WIDTH'(VECTOR_STRIDE);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        PUSH,
        VECTOR,
        SERVICE
    } state_t;

    state_t               state, state_d;
    logic [N_IRQ-1:0]     irq_prev;
    logic [N_IRQ-1:0]     mask;
    logic [N_IRQ-1:0]     req;
    logic [N_IRQ-1:0]     cap_onehot;
    logic [ID_W-1:0]      cap_id;
    logic                 capture;
    logic [DRAIN_W-1:0]   drain_cnt, drain_cnt_d;
    logic [WORD_W-1:0]    word_idx, word_idx_d;
    logic [PC_WIDTH-1:0]  pc_saved;
    logic [2:0]           flags_saved;

    // Vector address wraps modulo 2^PC_WIDTH.
    function automatic logic [PC_WIDTH-1:0] vector_pc(input logic [ID_W-1:0] id);
        return VECTOR_BASE + PC_WIDTH'(id) * STRIDE_PC;
    endfunction

    assign req     = pending & mask;
    assign capture = (state == IDLE) && (|req) && !branch_pending;

    // Fixed priority: scan downward so the lowest set index is the last to win.
    always_comb begin
        cap_id     = '0;
        cap_onehot = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                cap_id = ID_W'(i);
            end
        end
        if (capture) begin
            cap_onehot[cap_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending  <= '0;
            irq_prev <= '0;
            mask     <= '1;
        end else begin
            irq_prev <= irq_in;
            if (EDGE_MODE) begin
                pending <= (pending & ~cap_onehot) | (irq_in & ~irq_prev);
            end else begin
                pending <= irq_in;
            end
            if (mask_we) begin
                mask <= mask_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            word_idx  <= '0;
            active_id <= '0;
        end else begin
            state     <= state_d;
            drain_cnt <= drain_cnt_d;
            word_idx  <= word_idx_d;
            if (capture) begin
                active_id <= cap_id;
            end
        end
    end

    // Frame contents are only read in PUSH, which is always preceded by a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            pc_saved    <= pc_resume;
            flags_saved <= flags_in;
        end
    end

    always_comb begin
        state_d     = state;
        drain_cnt_d = drain_cnt;
        word_idx_d  = word_idx;
        push_valid  = 1'b0;
        stall_fetch = 1'b0;
        flush_fetch = 1'b0;
        pc_write    = 1'b0;
        pc_value    = '0;
        in_service  = 1'b0;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                stall_fetch = 1'b1;
                flush_fetch = 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    state_d    = PUSH;
                    word_idx_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt + 1'b1;
                end
            end
            PUSH: begin
                stall_fetch = 1'b1;
                push_valid  = 1'b1;
                if (push_ready) begin
                    if (word_idx == WORD_LAST) begin
                        state_d = VECTOR;
                    end else begin
                        word_idx_d = word_idx + 1'b1;
                    end
                end
            end
            VECTOR: begin
                pc_write    = 1'b1;
                pc_value    = vector_pc(active_id);
                flush_fetch = 1'b1;
                state_d     = SERVICE;
            end
            SERVICE: begin
                in_service = 1'b1;
                if (rti) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stack frame order: PC most-significant halfword first, flags word last.
    always_comb begin
        push_data = '0;
        if (state == PUSH) begin
            if (word_idx == WORD_LAST) begin
                push_data = {13'b0, flags_saved};
            end else begin
                for (int w = 0; w < N_WORDS - 1; w++) begin
                    if (word_idx == WORD_W'(w)) begin
                        push_data = pc_saved[PC_WIDTH-1-16*w -: 16];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer with the default parameters (4 channels, 32-bit PC).
module tb_irq_sequencer;

    logic        clk;
    logic        rst;
    logic [3:0]  irq_in;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        branch_pending;
    logic [31:0] pc_resume;
    logic [2:0]  flags_in;
    logic        push_valid;
    logic [15:0] push_data;
    logic        push_ready;
    logic        stall_fetch;
    logic        flush_fetch;
    logic        pc_write;
    logic [31:0] pc_value;
    logic        rti;
    logic        in_service;
    logic [1:0]  active_id;
    logic [3:0]  pending;

    int passes = 0;
    int total  = 0;

    irq_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .irq_in         (irq_in),
        .mask_we        (mask_we),
        .mask_wdata     (mask_wdata),
        .branch_pending (branch_pending),
        .pc_resume      (pc_resume),
        .flags_in       (flags_in),
        .push_valid     (push_valid),
        .push_data      (push_data),
        .push_ready     (push_ready),
        .stall_fetch    (stall_fetch),
        .flush_fetch    (flush_fetch),
        .pc_write       (pc_write),
        .pc_value       (pc_value),
        .rti            (rti),
        .in_service     (in_service),
        .active_id      (active_id),
        .pending        (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called in the capture cycle; walks DRAIN, PUSH, VECTOR and lands in SERVICE.
    task automatic run_seq(input logic [1:0] id, input logic [31:0] pc,
                           input logic [2:0] fl, input logic [31:0] vec);
        step();
        chk("drain1_stall", stall_fetch, 1);
        chk("drain1_flush", flush_fetch, 1);
        chk("drain1_pv", push_valid, 0);
        chk("cap_id", active_id, id);
        step();
        step();
        chk("drain3_flush", flush_fetch, 1);
        chk("drain3_pv", push_valid, 0);
        step();
        chk("push0_pv", push_valid, 1);
        chk("push0_stall", stall_fetch, 1);
        chk("push0_flush", flush_fetch, 0);
        chk("push0_data", push_data, pc[31:16]);
        step();
        chk("push1_data", push_data, pc[15:0]);
        step();
        chk("push2_data", push_data, {13'b0, fl});
        step();
        chk("vec_pcw", pc_write, 1);
        chk("vec_pc", pc_value, vec);
        chk("vec_flush", flush_fetch, 1);
        chk("vec_stall", stall_fetch, 0);
        chk("vec_pv", push_valid, 0);
        step();
        chk("svc_in", in_service, 1);
        chk("svc_pcw", pc_write, 0);
        chk("svc_id", active_id, id);
    endtask

    task automatic do_rti();
        rti = 1'b1;
        step();
        rti = 1'b0;
        chk("rti_idle", in_service, 0);
    endtask

    initial begin
        rst = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
        branch_pending = 1'b0; pc_resume = '0; flags_in = '0;
        push_ready = 1'b1; rti = 1'b0;
        step(); step(); step();
        chk("rst_pv", push_valid, 0);
        chk("rst_data", push_data, 0);
        chk("rst_stall", stall_fetch, 0);
        chk("rst_flush", flush_fetch, 0);
        chk("rst_pcw", pc_write, 0);
        chk("rst_pcv", pc_value, 0);
        chk("rst_svc", in_service, 0);
        chk("rst_id", active_id, 0);
        chk("rst_pend", pending, 0);
        rst = 1'b1;
        step();

        // Single channel 2
        pc_resume = 32'h0001_2345; flags_in = 3'b101; irq_in = 4'b0100;
        step();
        irq_in = 4'b0000;
        chk("a_pend", pending, 4'b0100);
        chk("a_capcyc_stall", stall_fetch, 0);
        run_seq(2'd2, 32'h0001_2345, 3'b101, 32'h4);
        chk("a_pend_clr", pending, 0);
        do_rti();

        // Simultaneous channels 1 and 3
        pc_resume = 32'hABCD_0010; flags_in = 3'b010; irq_in = 4'b1010;
        step();
        irq_in = 4'b0000;
        run_seq(2'd1, 32'hABCD_0010, 3'b010, 32'h2);
        chk("b_pend3", pending, 4'b1000);
        do_rti();
        run_seq(2'd3, 32'hABCD_0010, 3'b010, 32'h6);
        chk("b_pend_empty", pending, 0);
        do_rti();

        // Masked channel 0
        mask_we = 1'b1; mask_wdata = 4'b1110;
        step();
        mask_we = 1'b0;
        pc_resume = 32'hFFFF_0000; flags_in = 3'b111; irq_in = 4'b0001;
        step();
        irq_in = 4'b0000;
        chk("c_pend", pending, 4'b0001);
        step();
        chk("c_masked1", stall_fetch, 0);
        step();
        chk("c_masked2", stall_fetch, 0);
        mask_we = 1'b1; mask_wdata = 4'b1111;
        step();
        mask_we = 1'b0;
        chk("c_capcyc", stall_fetch, 0);
        run_seq(2'd0, 32'hFFFF_0000, 3'b111, 32'h0);
        do_rti();

        // Backpressure on the second word
        pc_resume = 32'h0001_2345; flags_in = 3'b101; irq_in = 4'b0100;
        step();
        irq_in = 4'b0000;
        step(); step(); step();
        chk("d_drain", flush_fetch, 1);
        step();
        chk("d_w0", push_data, 16'h0001);
        step();
        chk("d_w1", push_data, 16'h2345);
        push_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("d_hold_data", push_data, 16'h2345);
            chk("d_hold_pv", push_valid, 1);
            chk("d_hold_stall", stall_fetch, 1);
            chk("d_hold_pcw", pc_write, 0);
        end
        push_ready = 1'b1;
        step();
        chk("d_w2", push_data, 16'h0005);
        step();
        chk("d_pcw", pc_write, 1);
        chk("d_pcv", pc_value, 32'h4);
        step();
        chk("d_svc", in_service, 1);
        do_rti();

        // Capture deferred by an unresolved branch
        pc_resume = 32'h1234_5678; flags_in = 3'b001;
        branch_pending = 1'b1; irq_in = 4'b0010;
        step();
        irq_in = 4'b0000;
        chk("e_pend", pending, 4'b0010);
        chk("e_bp1", stall_fetch, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("e_bp_hold", stall_fetch, 0);
        end
        branch_pending = 1'b0;
        run_seq(2'd1, 32'h1234_5678, 3'b001, 32'h2);
        do_rti();

        // Request during SERVICE, then reset in the middle of the push
        pc_resume = 32'h0000_0040; flags_in = 3'b000; irq_in = 4'b0100;
        step();
        irq_in = 4'b0000;
        run_seq(2'd2, 32'h0000_0040, 3'b000, 32'h4);
        irq_in = 4'b0001;
        step();
        irq_in = 4'b0000;
        chk("f_pend_svc", pending, 4'b0001);
        chk("f_svc_nonest", in_service, 1);
        step();
        chk("f_svc_stall", stall_fetch, 0);
        do_rti();
        step(); step(); step(); step();
        chk("f_push", push_valid, 1);
        rst = 1'b0;
        step();
        chk("f_rst_pv", push_valid, 0);
        chk("f_rst_data", push_data, 0);
        chk("f_rst_stall", stall_fetch, 0);
        chk("f_rst_flush", flush_fetch, 0);
        chk("f_rst_pcw", pc_write, 0);
        chk("f_rst_svc", in_service, 0);
        chk("f_rst_id", active_id, 0);
        chk("f_rst_pend", pending, 0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("f_post_stall", stall_fetch, 0);
            chk("f_post_pend", pending, 0);
        end

        // A line high across reset release counts as an edge
        rst = 1'b0; irq_in = 4'b0001;
        step();
        chk("g_rst_pend", pending, 0);
        rst = 1'b1;
        step();
        chk("g_edge_pend", pending, 4'b0001);
        irq_in = 4'b0000;
        step();
        chk("g_drain", stall_fetch, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
